// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: req/ack front end -> non-pipelined SINGLE transfers.
// Optional data-phase watchdog enabled by defining AHB_MST_TIMEOUT_EN.
module ahb_lite_master #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          req,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic [31:0]   req_wd,
  output logic          ack,
  output logic [31:0]   rd,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [31:0]   hwdata,
  input  logic [31:0]   hrdata,
  input  logic          hready,
  input  logic [1:0]    hresp
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] wd_q;
  logic        misaligned;
  logic        tmo;

  always_comb begin
    misaligned = (req_size == 2'd3) ||
                 ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  end

`ifdef AHB_MST_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;
  logic [CW-1:0] tmo_cnt;

  // Counter sits at zero outside DATA, so entering DATA always starts a fresh count.
  always_ff @(posedge hclk) begin
    if (hreset)                tmo_cnt <= '0;
    else if (state != S_DATA)  tmo_cnt <= '0;
    else if (!hready)          tmo_cnt <= tmo_cnt + CW'(1);
  end

  // Fires on the wait cycle that brings the count to TIMEOUT; hready=1 wins.
  assign tmo = (state == S_DATA) && !hready && (tmo_cnt == CW'(TIMEOUT-1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = misaligned ? S_RESP : S_ADDR;
      S_ADDR: if (hready) state_nxt = S_DATA;
      S_DATA: if (hready || tmo) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr  <= '0;
      hwrite <= 1'b0;
      hsize  <= 3'b000;
      hwdata <= '0;
      wd_q   <= '0;
      rd     <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          haddr  <= req_addr;
          hwrite <= req_we;
          hsize  <= {1'b0, req_size};
          wd_q   <= req_wd;
          err    <= misaligned;
        end
        S_ADDR: if (hready && hwrite) hwdata <= wd_q;
        S_DATA: begin
          if (hready) begin
            err <= (hresp == 2'b01);
            // Errored reads leave the previous read data intact.
            if (!hwrite && (hresp != 2'b01)) rd <= hrdata;
          end else if (tmo) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign htrans = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign busy   = (state != S_IDLE);
  assign ack    = (state == S_RESP);
  assign hburst = 3'b000;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: vector table driven through a small slave model, scoreboard on ack.
module tb_ahb_lite_master;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        req, req_we;
  logic [31:0] req_addr, req_wd, hrdata, rd, haddr, hwdata;
  logic [1:0]  req_size, htrans, hresp;
  logic        ack, err, busy, hwrite, hready;
  logic [2:0]  hsize, hburst;

  ahb_lite_master #(.AW(32), .TIMEOUT(8)) dut (
    .hclk(hclk), .hreset(hreset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_wd(req_wd), .ack(ack), .rd(rd), .err(err), .busy(busy),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wd;
    int          aw;     // address-phase wait states
    int          dw;     // data-phase wait states
    logic        serr;   // slave answers ERROR (two-cycle)
    logic [31:0] rdata;
    logic        ill;    // expected: rejected without a bus transfer
  } vec_t;

  typedef struct { logic err; logic [31:0] rd; } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rd;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic e, input logic [31:0] r);
    exp_t x;
    x.err = e;
    x.rd  = r;
    sb.push_back(x);
  endtask

  always @(negedge hclk) begin
    if (!hreset && ack === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_err", {31'd0, err}, {31'd0, x.err});
        chk("sb_rd", rd, x.rd);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic e;
    @(posedge hclk); #1;
    req = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size; req_wd = v.wd;
    hready = 1'b1; hresp = 2'b00;
    e = v.ill | v.serr;
    if (!v.we && !e) model_rd = v.rdata;
    push(e, model_rd);
    @(negedge hclk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_htrans", {30'd0, htrans}, 32'd0);
    @(posedge hclk); #1;
    req = 1'b0; req_addr = $urandom; req_wd = $urandom; req_we = ~v.we; req_size = 2'($urandom);
    if (v.ill) begin
      @(negedge hclk);
      chk("ill_ack", {31'd0, ack}, 32'd1);
      chk("ill_htrans", {30'd0, htrans}, 32'd0);
    end else begin
      for (int i = 0; i <= v.aw; i++) begin
        hready = (i == v.aw);
        @(negedge hclk);
        chk("addr_htrans", {30'd0, htrans}, 32'h2);
        chk("addr_haddr", haddr, v.addr);
        chk("addr_hwrite", {31'd0, hwrite}, {31'd0, v.we});
        chk("addr_hsize", {29'd0, hsize}, {30'd0, v.size});
        @(posedge hclk); #1;
      end
      for (int i = 0; i <= v.dw; i++) begin
        hready = (i == v.dw);
        hresp  = (v.serr && (i >= v.dw - 1)) ? 2'b01 : 2'b00;
        hrdata = (i == v.dw) ? v.rdata : $urandom;
        @(negedge hclk);
        chk("data_htrans", {30'd0, htrans}, 32'd0);
        chk("data_noack", {31'd0, ack}, 32'd0);
        if (v.we) chk("data_hwdata", hwdata, v.wd);
        @(posedge hclk); #1;
      end
      hready = 1'b1; hresp = 2'b00;
      @(negedge hclk);
      chk("resp_ack", {31'd0, ack}, 32'd1);
    end
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("post_ack", {31'd0, ack}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  // Start a read and leave it parked in the data phase with hready low.
  task automatic start_stalled_read(input logic [31:0] a);
    @(posedge hclk); #1;
    req = 1'b1; req_we = 1'b0; req_addr = a; req_size = 2'd2; hready = 1'b1; hresp = 2'b00;
    @(posedge hclk); #1;
    req = 1'b0;
    @(posedge hclk); #1;
    hready = 1'b0;
  endtask

  task automatic reset_abort(input string nm);
    int acks;
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk({nm, "_htrans"}, {30'd0, htrans}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_rd"}, rd, 32'd0);
    hreset = 1'b0; hready = 1'b1; model_rd = '0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge hclk);
      if (ack === 1'b1) acks++;
    end
    chk({nm, "_noack"}, acks, 0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h04, 2'd2, 32'h0,        0, 3, 1'b0, 32'h12345678, 1'b0};
    tbl[2] = '{1'b1, 32'h20, 2'd2, 32'hA5A50000, 0, 1, 1'b1, 32'h0,        1'b0};
    tbl[3] = '{1'b0, 32'h08, 2'd2, 32'h0,        0, 0, 1'b0, 32'hCAFEF00D, 1'b0};
    tbl[4] = '{1'b1, 32'h02, 2'd2, 32'h11111111, 0, 0, 1'b0, 32'h0,        1'b1};
    tbl[5] = '{1'b0, 32'h00, 2'd3, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1};
    tbl[6] = '{1'b0, 32'h13, 2'd0, 32'h0,        2, 0, 1'b0, 32'h000000AB, 1'b0};
    tbl[7] = '{1'b1, 32'h06, 2'd1, 32'h12340000, 0, 1, 1'b0, 32'h0,        1'b0};
    tbl[8] = '{1'b0, 32'h05, 2'd1, 32'h0,        0, 0, 1'b0, 32'h0,        1'b1};
    tbl[9] = '{1'b0, 32'h0C, 2'd2, 32'h0,        0, 0, 1'b0, 32'h5555AAAA, 1'b0};

    hreset = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wd = '0;
    hrdata = '0; hready = 1'b1; hresp = 2'b00; model_rd = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
    chk("rst_hsize", {29'd0, hsize}, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_hburst", {29'd0, hburst}, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Back-to-back: req held through the first ack is taken in the next IDLE cycle.
    for (int c = 0; c <= 8; c++) begin
      logic exp_ack;
      @(posedge hclk); #1;
      if (c == 0) begin
        req = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_size = 2'd2; req_wd = 32'h0BADF00D;
        hready = 1'b1; hresp = 2'b00;
        push(1'b0, model_rd);
        push(1'b0, model_rd);
      end
      if (c == 5) req = 1'b0;
      exp_ack = (c == 3) || (c == 7);
      @(negedge hclk);
      chk("b2b_ack", {31'd0, ack}, {31'd0, exp_ack});
    end

    start_stalled_read(32'h40);
    @(negedge hclk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset_abort("midrst");

`ifdef AHB_MST_TIMEOUT_EN
    begin
      int n;
      start_stalled_read(32'h44);
      push(1'b1, model_rd);
      n = 0;
      while (n < 50) begin
        @(negedge hclk);
        if (ack === 1'b1) break;
        n++;
        @(posedge hclk); #1;
      end
      chk("tmo_waits", n, 8);
      @(posedge hclk); #1;
      hready = 1'b1;
    end
`else
    begin
      int nb;
      start_stalled_read(32'h44);
      nb = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge hclk);
        if (busy === 1'b1) nb++;
      end
      chk("hang_busy", nb, 1000);
      reset_abort("hangrst");
    end
`endif

    run_vec(tbl[9]);
    repeat (2) @(posedge hclk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
Single-outstanding AHB-Lite initiator that turns a simple request/acknowledge bus (addr/we/wd/size, ack/rd/err) into non-pipelined AHB-Lite SINGLE transfers. It is the initiator-side counterpart of the codebase's AHB slave peripherals such as the UART. A core, DMA or debug port uses it to reach the peripheral AHB segment. One transfer is in flight at a time: address phase, then data phase, then a one-cycle ack.

Parameters:
AW, 32, address width of req_addr and haddr
TIMEOUT, 255, cycles hready may stay low in the data phase before abort (used only with AHB_MST_TIMEOUT_EN)

Ports:
hclk  input  1  AHB clock; all logic is on its rising edge
hreset  input  1  synchronous reset, active-high
req  input  1  request valid; sampled only in IDLE
req_we  input  1  1=write, 0=read
req_addr  input  AW  byte address
req_size  input  2  0=byte, 1=half, 2=word; 3 is illegal
req_wd  input  32  write data, already lane-positioned by the requester
ack  output  1  one-cycle pulse when the transfer completes
rd  output  32  read data; valid in the ack cycle, held until the next ack
err  output  1  valid with ack; 1=slave ERROR, misalignment or timeout
busy  output  1  high whenever state is not IDLE
haddr  output  AW  AHB address
htrans  output  2  AHB transfer type: IDLE=2'b00, NONSEQ=2'b10
hwrite  output  1  AHB write
hsize  output  3  AHB size, {1'b0,req_size}
hburst  output  3  constant 3'b000 (SINGLE)
hwdata  output  32  AHB write data
hrdata  input  32  AHB read data
hready  input  1  AHB ready
hresp  input  2  AHB response; 2'b01=ERROR

Behaviour:
- Reset (synchronous, hreset=1 at a rising edge): state=IDLE. These outputs reset to 0: ack, err, busy, rd, haddr, htrans, hwrite, hsize, hwdata. hburst is always 0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - htrans=IDLE.
  - When req=1, capture we/addr/size/wd into internal registers.
  - Legal and aligned request -> go to ADDR.
  - Alignment rule: size 1 requires addr[0]=0; size 2 requires addr[1:0]=0; size 3 is always illegal.
  - Misaligned or illegal request -> go to RESP with err=1. No AHB transfer is issued.
- ADDR:
  - Drive htrans=NONSEQ with the captured haddr/hwrite/hsize.
  - hready=1 -> go to DATA.
  - hready=0 -> stay in ADDR with all address-phase signals held stable.
- DATA:
  - Drive htrans=IDLE. Hold haddr/hwrite/hsize at their last values.
  - Drive hwdata=captured wd for the whole phase on writes; hwdata is don't-care on reads and keeps its last value.
  - hready=1 -> go to RESP. Register rd=hrdata on reads; rd is unchanged on writes. Register err=(hresp==2'b01).
  - hready=0 with hresp=ERROR (first error cycle) -> stay in DATA. No new transfer is started; the slave's second cycle is awaited.
- RESP: ack=1 for exactly one cycle, err valid, then go to IDLE.
- Latency, zero-wait slave: req accepted at cycle 0, NONSEQ in cycle 1, data phase in cycle 2, ack in cycle 3. Each slave wait state adds one cycle.
- Back-to-back: req held high through the ack cycle is accepted in the following IDLE cycle. Minimum spacing is 4 cycles per transfer.
- req changes outside IDLE are ignored; captured values are used.
- Reset mid-transfer: immediate return to IDLE, htrans=IDLE, no ack. The slave is expected to be reset by the same reset.
- busy=1 in ADDR, DATA and RESP.

Optional Feature:
AHB_MST_TIMEOUT_EN
- Defined:
  - An 8+ bit counter (width = clog2(TIMEOUT+1)) clears on entry to DATA and increments on each hready=0 cycle.
  - When the count reaches TIMEOUT with hready still 0 -> go to RESP with err=1; rd is unchanged.
  - hready=1 on the same cycle the count reaches TIMEOUT: normal completion wins.
- Not defined: no counter is built; DATA waits indefinitely for hready.

Test Plan:
1. Zero-wait word write: req_addr=0x0000_0010, req_wd=0xDEAD_BEEF, size=2, hready=1 -> NONSEQ in cycle 1 with haddr=0x10, hsize=3'b010, hwrite=1; hwdata=0xDEADBEEF in cycle 2; ack=1, err=0 in cycle 3.
2. Read with 3 wait states: read 0x04, slave drives hrdata=0x1234_5678 and holds hready=0 for 3 data-phase cycles -> ack at cycle 6 with rd=0x12345678; htrans=IDLE throughout the data phase.
3. Slave error: two-cycle ERROR response (hready=0/hresp=01, then hready=1/hresp=01) -> ack=1, err=1; rd keeps its previous value; next req proceeds normally.
4. Misalignment: word request at 0x02, then size=3 at 0x00 -> each gives ack=1, err=1 one cycle after acceptance; htrans stays 2'b00 throughout.
5. Reset mid-transfer: hreset=1 during DATA with hready=0 -> next edge gives state IDLE, htrans=0, busy=0; no ack ever pulses for the aborted transfer.
6. Timeout (macro defined, TIMEOUT=8): hready held 0 in data phase -> ack=1, err=1 after 8 wait cycles. With the macro undefined, busy remains 1 for 1000 cycles.
